// File: rtl/convolutional_encoder_pkg.sv
// Shared constants for the K=7 convolutional encoder: rate codes, generators and puncturing masks.
// Masks are only consumed when CONV_ENC_PUNCTURE_EN is defined.
package convolutional_encoder_pkg;

   typedef enum logic [1:0] {
      RATE_1_2     = 2'b00,
      RATE_2_3     = 2'b01,
      RATE_3_4     = 2'b10,
      RATE_1_2_ALT = 2'b11
   } rate_e;

   localparam int unsigned K       = 7;
   localparam logic [K-1:0] G0     = 7'o133;
   localparam logic [K-1:0] G1     = 7'o171;
   localparam int unsigned PHASE_W = 2;

   // Mask bit 1 keeps A, bit 0 keeps B
   localparam logic [1:0] KEEP_AB = 2'b11;
   localparam logic [1:0] KEEP_A  = 2'b10;
   localparam logic [1:0] KEEP_B  = 2'b01;

   localparam logic [1:0] MASK_R12 [1] = '{KEEP_AB};
   localparam logic [1:0] MASK_R23 [2] = '{KEEP_AB, KEEP_A};
   localparam logic [1:0] MASK_R34 [3] = '{KEEP_AB, KEEP_A, KEEP_B};

   function automatic logic [1:0] rate_period(input rate_e r);
      case (r)
         RATE_2_3: rate_period = 2'd2;
         RATE_3_4: rate_period = 2'd3;
         default:  rate_period = 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/convolutional_encoder_puncturer.sv
// conv_puncturer: maps the latched rate and puncturing phase to keep-A/keep-B and the wrapped next phase.
// Instantiated by convolutional_encoder only when CONV_ENC_PUNCTURE_EN is defined.
module conv_puncturer
   import convolutional_encoder_pkg::*;
(
   input  rate_e              rate_i,
   input  logic [PHASE_W-1:0] phase_i,
   output logic               keep_a_o,
   output logic               keep_b_o,
   output logic [PHASE_W-1:0] phase_next_o
);

   logic [1:0] mask;

   always_comb begin
      mask = MASK_R12[0];
      case (rate_i)
         RATE_2_3: mask = MASK_R23[phase_i[0]];
         RATE_3_4: if (phase_i < 2'd3) mask = MASK_R34[phase_i];
         default:  mask = MASK_R12[0];
      endcase
   end

   always_comb begin
      phase_next_o = '0;
      if (int'(phase_i) + 1 < int'(rate_period(rate_i))) begin
         phase_next_o = phase_i + 1'b1;
      end
   end

   assign keep_a_o = mask[1];
   assign keep_b_o = mask[0];

endmodule

// File: rtl/convolutional_encoder.sv
// 802.11a K=7 rate-1/2 convolutional encoder with a 2-entry output buffer and valid/ready handshakes.
// Define CONV_ENC_PUNCTURE_EN to add rate 2/3 and 3/4 puncturing selected by Rate on Start.
module convolutional_encoder
   import convolutional_encoder_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] Rate,
   input  logic       InBit,
   input  logic       InValid,
   output logic       InReady,
   output logic       OutBit,
   output logic       OutValid,
   input  logic       OutReady
);

   // hist_q[K-2] is d1 (newest), hist_q[0] is d6
   logic [K-2:0] hist_q, hist_d;
   logic [1:0]   buf_q, buf_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [K-1:0] sr;
   logic         code_a, code_b;
   logic         keep_a, keep_b;
   logic         pop, accept;

`ifdef CONV_ENC_PUNCTURE_EN
   rate_e              rate_q, rate_d;
   logic [PHASE_W-1:0] phase_q, phase_d, phase_next;

   conv_puncturer u_punc (
      .rate_i       (rate_q),
      .phase_i      (phase_q),
      .keep_a_o     (keep_a),
      .keep_b_o     (keep_b),
      .phase_next_o (phase_next)
   );
`else
   logic unused_rate;
   assign unused_rate = ^Rate;
   assign keep_a      = 1'b1;
   assign keep_b      = 1'b1;
`endif

   assign sr       = {InBit, hist_q};
   assign code_a   = ^(sr & G0);
   assign code_b   = ^(sr & G1);
   assign OutValid = (cnt_q != 2'd0);
   assign OutBit   = OutValid & buf_q[0];
   assign pop      = OutValid & OutReady;
   assign InReady  = ~Start & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pop));
   assign accept   = InValid & InReady;

   always_comb begin
      hist_d = hist_q;
      buf_d  = buf_q;
      cnt_d  = cnt_q;
`ifdef CONV_ENC_PUNCTURE_EN
      rate_d  = rate_q;
      phase_d = phase_q;
`endif
      if (Start) begin
         hist_d = '0;
         buf_d  = '0;
         cnt_d  = '0;
`ifdef CONV_ENC_PUNCTURE_EN
         rate_d  = rate_e'(Rate);
         phase_d = '0;
`endif
      end else begin
         if (pop) begin
            buf_d = {1'b0, buf_q[1]};
            cnt_d = cnt_q - 2'd1;
         end
         // Acceptance implies the buffer is empty after any pop, so a full overwrite is safe
         if (accept) begin
            hist_d = sr[K-1:1];
`ifdef CONV_ENC_PUNCTURE_EN
            phase_d = phase_next;
`endif
            case ({keep_a, keep_b})
               2'b11: begin buf_d = {code_b, code_a}; cnt_d = 2'd2; end
               2'b10: begin buf_d = {1'b0, code_a};   cnt_d = 2'd1; end
               2'b01: begin buf_d = {1'b0, code_b};   cnt_d = 2'd1; end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         hist_q <= '0;
         buf_q  <= '0;
         cnt_q  <= '0;
`ifdef CONV_ENC_PUNCTURE_EN
         rate_q  <= RATE_1_2;
         phase_q <= '0;
`endif
      end else begin
         hist_q <= hist_d;
         buf_q  <= buf_d;
         cnt_q  <= cnt_d;
`ifdef CONV_ENC_PUNCTURE_EN
         rate_q  <= rate_d;
         phase_q <= phase_d;
`endif
      end
   end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Bench for convolutional_encoder: queue-based reference model checked every cycle plus literal streams.
// Follows CONV_ENC_PUNCTURE_EN so the same bench serves both builds.
module tb_convolutional_encoder;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic [1:0] Rate = 2'b00;
   logic       InBit = 1'b0;
   logic       InValid = 1'b0;
   logic       OutReady = 1'b1;
   logic       InReady, OutBit, OutValid;

   convolutional_encoder dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Rate     (Rate),
      .InBit    (InBit),
      .InValid  (InValid),
      .InReady  (InReady),
      .OutBit   (OutBit),
      .OutValid (OutValid),
      .OutReady (OutReady)
   );

   always #5 Clock = ~Clock;

   int tests = 0;
   int fails = 0;

   bit mq[$];
   bit cap[$];
   int mh[7];
   int mrate = 0;
   int mphase = 0;
   bit m_init = 1'b0;
   bit m_acc = 1'b0;
   bit ev, er;
   int ma, mb, keep;

   bit impulse[$]  = '{1, 0, 0, 0, 0, 0, 0};
   bit lit12[$]    = '{1,1, 0,1, 1,1, 1,1, 0,0, 1,0, 1,1};
   bit lit34[$]    = '{1,1, 0, 1, 1,1, 0, 0, 1,1};
   bit zeros4[$]   = '{0, 0, 0, 0};
   bit lit23z[$]   = '{0, 0, 0, 0, 0, 0};
   bit lit12z[$]   = '{0, 0, 0, 0, 0, 0, 0, 0};

   function automatic void check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Keep pattern straight from the rate table: 2 = A only, 1 = B only, 3 = both
   function automatic int keep_for(input int rate, input int phase);
      if (rate == 1) return (phase == 0) ? 3 : 2;
      if (rate == 2) return (phase == 0) ? 3 : ((phase == 1) ? 2 : 1);
      return 3;
   endfunction

   function automatic int period_for(input int rate);
      if (rate == 1) return 2;
      if (rate == 2) return 3;
      return 1;
   endfunction

   always @(negedge Clock) begin
      m_acc = 1'b0;
      if (Reset) begin
         mq.delete();
         foreach (mh[i]) mh[i] = 0;
         mrate  = 0;
         mphase = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         ev = (mq.size() != 0);
         er = !Start && (mq.size() == 0 || (mq.size() == 1 && OutReady));
         check("out_valid", OutValid, ev);
         if (ev) check("out_bit", OutBit, mq[0]);
         check("in_ready", InReady, er);
         if (Start) begin
            mq.delete();
            foreach (mh[i]) mh[i] = 0;
            mphase = 0;
`ifdef CONV_ENC_PUNCTURE_EN
            mrate = int'(Rate);
`else
            mrate = 0;
`endif
         end else begin
            if (ev && OutReady) begin
               cap.push_back(OutBit);
               void'(mq.pop_front());
            end
            if (InValid && er) begin
               mh[0] = int'(InBit);
               ma = mh[0] ^ mh[2] ^ mh[3] ^ mh[5] ^ mh[6];
               mb = mh[0] ^ mh[1] ^ mh[2] ^ mh[3] ^ mh[6];
               keep = keep_for(mrate, mphase);
               if (keep >= 2) mq.push_back(ma[0]);
               if (keep[0]) mq.push_back(mb[0]);
               for (int i = 6; i >= 1; i--) mh[i] = mh[i-1];
               mphase = (mphase + 1) % period_for(mrate);
               m_acc = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic send(input bit b);
      int n = 0;
      InValid = 1'b1;
      InBit   = b;
      forever begin
         @(posedge Clock);
         if (m_acc) break;
         n++;
         if (n > 40) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: input not accepted after %0d cycles", n);
            break;
         end
      end
      #1;
      InValid = 1'b0;
   endtask

   task automatic send_seq(input bit s[$]);
      foreach (s[i]) send(s[i]);
   endtask

   task automatic start_frame(input logic [1:0] r);
      Start = 1'b1;
      Rate  = r;
      tick();
      Start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      OutReady = 1'b1;
      while (mq.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (mq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d bits still expected", mq.size());
      end
      tick();
   endtask

   task automatic check_cap(input string name, input bit exp[$]);
      check_int({name, "_len"}, cap.size(), exp.size());
      foreach (exp[i]) begin
         if (i < cap.size()) check(name, cap[i], exp[i]);
      end
   endtask

   initial begin
      repeat (3) tick();
      Reset = 1'b0;
      tick();
      check("rst_out_valid", OutValid, 1'b0);
      check("rst_out_bit", OutBit, 1'b0);
      check("rst_in_ready", InReady, 1'b1);

      // Impulse at rate 1/2
      start_frame(2'b00);
      cap.delete();
      send_seq(impulse);
      drain();
      check_cap("imp_r12", lit12);

      // Impulse at rate 3/4 with a mid-frame Rate change that must be ignored
      start_frame(2'b10);
      Rate = 2'b00;
      cap.delete();
      send_seq(impulse);
      drain();
`ifdef CONV_ENC_PUNCTURE_EN
      check_cap("imp_r34", lit34);
`else
      check_cap("imp_r34_nopunct", lit12);
`endif

      // All-zero input at rate 2/3
      start_frame(2'b01);
      cap.delete();
      send_seq(zeros4);
      drain();
`ifdef CONV_ENC_PUNCTURE_EN
      check_cap("zero_r23", lit23z);
`else
      check_cap("zero_r23_nopunct", lit12z);
`endif

      // Backpressure mid-stream
      start_frame(2'b00);
      cap.delete();
      fork
         send_seq(impulse);
         begin
            repeat (2) tick();
            OutReady = 1'b0;
            repeat (3) tick();
            check("bp_in_ready_full", InReady, 1'b0);
            repeat (2) tick();
            OutReady = 1'b1;
         end
      join
      drain();
      check_cap("bp_stream", lit12);

      // Start while a handshake is pending: flush, ignore offered input
      start_frame(2'b00);
      OutReady = 1'b0;
      send(1'b1);
      tick();
      OutReady = 1'b1;
      InValid  = 1'b1;
      InBit    = 1'b1;
      start_frame(2'b00);
      InValid  = 1'b0;
      check("start_flush_valid", OutValid, 1'b0);
      cap.delete();
      send_seq(impulse);
      drain();
      check_cap("after_start", lit12);

      // Reset mid-frame: no further output, rate back to 1/2 with clear history
      start_frame(2'b10);
      OutReady = 1'b0;
      send(1'b1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("rst_mid_valid", OutValid, 1'b0);
      check("rst_mid_bit", OutBit, 1'b0);
      check("rst_mid_ready", InReady, 1'b1);
      OutReady = 1'b1;
      cap.delete();
      repeat (5) tick();
      check_int("rst_no_output", cap.size(), 0);
      send_seq(impulse);
      drain();
      check_cap("after_reset", lit12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule

// File: doc/convolutional_encoder.md
CONVOLUTIONAL_ENCODER -- requirements
Module: convolutional_encoder

Interface
- REQ-001 SHALL have one clock and a synchronous, active-high reset:
  - Clock  input  1  rising-edge clock for all state.
  - Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
- REQ-002 SHALL have the following data and handshake ports:
  - Start     input   1  one-cycle pulse that begins a frame.
  - Rate      input   2  coding-rate select, sampled on Start: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = 1/2.
  - InBit     input   1  scrambled data bit from the scrambler stage.
  - InValid   input   1  InBit is valid.
  - InReady   output  1  encoder can accept InBit this cycle.
  - OutBit    output  1  coded serial bit.
  - OutValid  output  1  OutBit is valid.
  - OutReady  input   1  downstream accepts OutBit this cycle.

Function
- REQ-003 SHALL implement the 802.11a K=7 code on a 6-bit history register d1..d6, where d1 is the newest previous bit and d0 = InBit:
  - A = d0^d2^d3^d5^d6 (g0 = 133 octal).
  - B = d0^d1^d2^d3^d6 (g1 = 171 octal).
- REQ-004 SHALL accept an input bit only in a cycle where InValid and InReady are both high.
- REQ-005 On acceptance, the encoder SHALL:
  - shift d0 into the history register;
  - load the unpunctured subset of {A, B} into a 2-entry output buffer, A before B.
- REQ-006 SHALL assert InReady when the output buffer is empty, or holds one bit that is being consumed this cycle (zero-bubble streaming).
- REQ-007 SHALL drive OutBit and OutValid from the buffer head, and pop one bit per cycle in which OutValid and OutReady are both high.
- REQ-008 SHALL hold OutBit stable while OutValid is high and OutReady is low.
- REQ-009 Puncturing SHALL use a phase counter that advances once per accepted input bit and wraps at the period:
  - Rate 1/2: period 1, keep A and B.
  - Rate 2/3: period 2; phase 0 keeps A and B, phase 1 keeps A only.
  - Rate 3/4: period 3; phase 0 keeps A and B, phase 1 keeps A only, phase 2 keeps B only.
- REQ-010 Start SHALL, in the same cycle, flush all frame state:
  - clear the history register;
  - reset the phase counter to 0;
  - discard the output buffer;
  - latch Rate.
- REQ-011 InReady SHALL be low in the cycle where Start is high, and any input offered with Start SHALL be ignored.
- REQ-012 SHALL keep the latched rate fixed between Start pulses; Rate changes mid-frame SHALL have no effect.
- REQ-013 Start coincident with a pending output handshake SHALL take priority: the bit is dropped, and OutValid is low in the next cycle.
- REQ-014 Latency SHALL be one cycle from input acceptance to the first coded bit appearing on OutValid.

Reset
- REQ-015 Reset SHALL clear all state and take priority over Start.
- REQ-016 On reset:
  - history register = 0, phase = 0, buffer empty;
  - latched rate = 1/2;
  - OutValid = 0, OutBit = 0, InReady = 1.
- REQ-017 Reset asserted mid-frame SHALL discard buffered bits with no further output.

Configuration
- REQ-018 With macro CONV_ENC_PUNCTURE_EN defined, SHALL support rates 1/2, 2/3 and 3/4 as in REQ-009.
- REQ-019 Without CONV_ENC_PUNCTURE_EN:
  - the phase counter and puncturing logic SHALL be absent;
  - Rate SHALL be ignored;
  - every input SHALL produce A then B (rate 1/2 only).

Structure
- REQ-020 A shared package SHALL hold:
  - the rate encoding constants;
  - the generator polynomials G0 = 7'o133 and G1 = 7'o171;
  - the constraint length 7;
  - the puncturing masks per rate and phase.
- REQ-021 SHALL contain one sub-module, conv_puncturer, mapping {rate, phase} to the keep-A/keep-B masks and the phase wrap.

Verification
- REQ-022 A bench SHALL cover these directed scenarios:
  - Impulse, rate 1/2: Start, then inputs 1,0,0,0,0,0,0 with OutReady=1 -> OutBit sequence 1,1,0,1,1,1,1,1,0,0,1,0,1,1.
  - Same impulse, rate 3/4: first 3 inputs -> 1,1,0,1 (A0,B0,A1,B2); 4 coded bits per 3 inputs.
  - Rate 2/3, 4 inputs all zero -> 6 output bits, all zero; phase wraps twice.
  - Backpressure: OutReady low for 5 cycles mid-stream -> OutBit held constant, InReady low once the buffer is full, no bit lost or duplicated.
  - Start mid-frame with a bit pending -> buffer flushed, next impulse reproduces the first scenario from a zero history.
  - Build without CONV_ENC_PUNCTURE_EN, Rate=10 -> output identical to the first scenario.
